// File: rtl/display_scan_gen.sv
// display_scan_gen: multiplexed N-digit 7-segment scan driver with prescaler, frame snapshot, LZS, blanking, PWM and hex decode
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   num          hex value, digit k = num[4k+3:4k] (digit 0 least significant)
//   pts          decimal point per digit, 1 = lit
//   blank        1 = digit k dark (segments and dp), select still scans
//   lzs_en       1 = leading-zero suppression
//   type_sel     1 = common cathode (active-high), 0 = common anode (active-low)
//   bright       PWM brightness, 0 = off .. 15 = full on
//   ssg          {dp,g,f,e,d,c,b,a}, registered
//   dctl         digit selects, registered, one-hot when active
//   frame_start  1-cycle pulse on the edge the frame snapshot is taken
module display_scan_gen #(
  parameter int N_DIGITS   = 6,
  parameter int DIV_CYCLES = 1000,
  parameter int GUARD      = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*N_DIGITS-1:0]   num,
  input  logic [N_DIGITS-1:0]     pts,
  input  logic [N_DIGITS-1:0]     blank,
  input  logic                    lzs_en,
  input  logic                    type_sel,
  input  logic [3:0]              bright,
  output logic [7:0]              ssg,
  output logic [N_DIGITS-1:0]     dctl,
  output logic                    frame_start
);
  localparam int PW = $clog2(DIV_CYCLES);
  localparam int DW = $clog2(N_DIGITS);
  logic [PW-1:0]           pre_cnt_q, pre_cnt_d;
  logic [DW-1:0]           dig_idx_q, dig_idx_d;
  logic [3:0]              pwm_cnt_q, pwm_cnt_d;
  logic                    first_q, first_d;
  logic [4*N_DIGITS-1:0]   num_s_q, num_s_d;
  logic [N_DIGITS-1:0]     pts_s_q, pts_s_d;
  logic [N_DIGITS-1:0]     blank_s_q, blank_s_d;
  logic                    lzs_s_q, lzs_s_d;
  logic [N_DIGITS-1:0]     dctl_q, dctl_d;
  logic [7:0]              ssg_q, ssg_d;
  logic                    fs_q, fs_d;
  logic                    pol_q, pol_d;
  logic                    live_q;
  logic                    pre_wrap, dig_wrap, snap, guard, pwm_on, z, pol;
  logic [N_DIGITS-1:0]     supp;
  logic [3:0]              nib;
  logic [7:0]              pat;
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction
  always_comb begin
    pre_wrap  = pre_cnt_q == PW'(DIV_CYCLES - 1);
    dig_wrap  = dig_idx_q == DW'(N_DIGITS - 1);
    // first wrap after reset also snapshots so the display leaves the all-zero state quickly
    snap      = pre_wrap & (dig_wrap | first_q);
    pre_cnt_d = pre_wrap ? '0 : pre_cnt_q + 1'b1;
    dig_idx_d = pre_wrap ? (dig_wrap ? '0 : dig_idx_q + 1'b1) : dig_idx_q;
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    first_d   = first_q & ~pre_wrap;
    num_s_d   = snap ? num : num_s_q;
    pts_s_d   = snap ? pts : pts_s_q;
    blank_s_d = snap ? blank : blank_s_q;
    lzs_s_d   = snap ? lzs_en : lzs_s_q;
    // z stays high while every nibble from the top down to k is zero
    z    = 1'b1;
    supp = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      z       = z & (num_s_q[4*k +: 4] == 4'h0);
      supp[k] = lzs_s_q & z & (k != 0);
    end
    nib    = 4'(num_s_q >> {dig_idx_q, 2'b00});
    pat    = blank_s_q[dig_idx_q] ? 8'h00 : {pts_s_q[dig_idx_q], supp[dig_idx_q] ? 7'h00 : hex7(nib)};
    guard  = pre_cnt_q < PW'(GUARD);
    pwm_on = (&bright) | (pwm_cnt_q < bright);
    dctl_d = guard ? '0 : {{(N_DIGITS-1){1'b0}}, 1'b1} << dig_idx_q;
    ssg_d  = (guard | ~pwm_on) ? 8'h00 : pat;
    fs_d   = snap;
    pol_d  = type_sel;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre_cnt_q <= '0;
      dig_idx_q <= '0;
      pwm_cnt_q <= '0;
      first_q   <= 1'b1;
      num_s_q   <= '0;
      pts_s_q   <= '0;
      blank_s_q <= '0;
      lzs_s_q   <= 1'b0;
      dctl_q    <= '0;
      ssg_q     <= '0;
      fs_q      <= 1'b0;
      pol_q     <= 1'b1;
      live_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      dig_idx_q <= dig_idx_d;
      pwm_cnt_q <= pwm_cnt_d;
      first_q   <= first_d;
      num_s_q   <= num_s_d;
      pts_s_q   <= pts_s_d;
      blank_s_q <= blank_s_d;
      lzs_s_q   <= lzs_s_d;
      dctl_q    <= dctl_d;
      ssg_q     <= ssg_d;
      fs_q      <= fs_d;
      pol_q     <= pol_d;
      live_q    <= 1'b1;
    end
  // dctl_q/ssg_q hold active-high levels; until the first clock after reset the
  // polarity follows type_sel directly so outputs read inactive for either display type
  assign pol         = live_q ? pol_q : type_sel;
  assign dctl        = pol ? dctl_q : ~dctl_q;
  assign ssg         = pol ? ssg_q : ~ssg_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_display_scan_gen.sv
// tb_display_scan_gen: table-driven scoreboard bench for display_scan_gen
module tb_display_scan_gen;
  localparam int N = 6, DIV = 4, G = 1, FR = N * DIV;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [23:0]  num = '0;
  logic [5:0]   pts = '0, blank = '0;
  logic         lzs_en = 1'b0, type_sel = 1'b0;
  logic [3:0]   bright = 4'd15;
  logic [7:0]   ssg;
  logic [5:0]   dctl;
  logic         frame_start;
  int           tests = 0, fails = 0, cyc = 0;
  logic [47:0]  es;
  logic [14:0]  q[$];
  typedef struct {
    logic [23:0] num;
    logic [5:0]  pts;
    logic [5:0]  blank;
    logic        lzs;
    logic        typ;
    logic [3:0]  br;
    logic [47:0] seg;
  } vec_t;
  vec_t vecs[8];
  display_scan_gen #(.N_DIGITS(N), .DIV_CYCLES(DIV), .GUARD(G)) dut (
    .clk(clk), .rst_n(rst_n), .num(num), .pts(pts), .blank(blank), .lzs_en(lzs_en),
    .type_sel(type_sel), .bright(bright), .ssg(ssg), .dctl(dctl), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic check1(input string name, input logic [14:0] act, input logic [14:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic chk(input int n);
    int k, p, d, pw;
    logic g, en, fs;
    logic [5:0] dc;
    logic [7:0] sg;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      k  = cyc;
      p  = (k - 1) % FR;
      d  = p / DIV;
      g  = (p % DIV) < G;
      pw = (k - 1) % 16;
      en = bright == 4'd15 || pw < int'(bright);
      dc = g ? 6'b0 : 6'b1 << d;
      sg = (g || !en) ? 8'h00 : es[8*d +: 8];
      if (!type_sel) begin
        dc = ~dc;
        sg = ~sg;
      end
      fs = (k == DIV) || (k % FR == 0);
      q.push_back({fs, dc, sg});
      @(negedge clk);
      check1($sformatf("scan k=%0d {fs,dctl,ssg}", k), {frame_start, dctl, ssg}, q.pop_front());
    end
  endtask
  task automatic wait_frame();
    for (int i = 0; i <= 2 * FR; i++) begin
      @(negedge clk);
      if (frame_start) return;
    end
    fails++;
    $display("FAIL frame_start timeout");
  endtask
  initial begin
    vecs[0] = '{24'h123456, 6'h00, 6'h00, 1'b0, 1'b1, 4'd15, {8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D}};
    vecs[1] = '{24'h123456, 6'h00, 6'h00, 1'b0, 1'b0, 4'd15, {8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D}};
    vecs[2] = '{24'h000102, 6'h08, 6'h00, 1'b1, 1'b1, 4'd15, {8'h00, 8'h00, 8'h80, 8'h06, 8'h3F, 8'h5B}};
    vecs[3] = '{24'hABCDEF, 6'h03, 6'h02, 1'b0, 1'b1, 4'd15, {8'h77, 8'h7C, 8'h39, 8'h5E, 8'h00, 8'hF1}};
    vecs[4] = '{24'h123456, 6'h00, 6'h00, 1'b0, 1'b1, 4'd4,  {8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D}};
    vecs[5] = '{24'h123456, 6'h00, 6'h00, 1'b0, 1'b1, 4'd0,  {8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D}};
    vecs[6] = '{24'h000000, 6'h00, 6'h00, 1'b1, 1'b1, 4'd15, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F}};
    vecs[7] = '{24'h100000, 6'h00, 6'h00, 1'b1, 1'b0, 4'd15, {8'h06, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F}};
    #23;
    check1("reset type0", {frame_start, dctl, ssg}, {1'b0, 6'h3F, 8'hFF});
    type_sel = 1'b1;
    #1;
    check1("reset type1", {frame_start, dctl, ssg}, {1'b0, 6'h00, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 8; v++) begin
      num = vecs[v].num;
      pts = vecs[v].pts;
      blank = vecs[v].blank;
      lzs_en = vecs[v].lzs;
      type_sel = vecs[v].typ;
      bright = vecs[v].br;
      es = vecs[v].seg;
      wait_frame();
      chk(FR);
    end
    // value change mid-frame stays invisible until the next snapshot
    num = 24'h111111;
    pts = '0;
    blank = '0;
    lzs_en = 1'b0;
    type_sel = 1'b1;
    bright = 4'd15;
    es = {6{8'h06}};
    wait_frame();
    chk(10);
    num = 24'h222222;
    chk(FR - 10);
    es = {6{8'h5B}};
    chk(FR);
    // reset in the middle of digit 3
    num = '0;
    es = {6{8'h3F}};
    wait_frame();
    chk(14);
    rst_n = 1'b0;
    #1;
    check1("midframe reset", {frame_start, dctl, ssg}, {1'b0, 6'h00, 8'h00});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk(FR);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
